// File: rtl/port_tx.sv
// port_tx: serial port transmitter (address, optional pad, payload, gap) fed by a one-packet holding register.
// Define PORT_TX_PAD_EN to insert PAD_CYCLES pad cycles between address and payload.
module port_tx #(
   parameter int PAD_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  addr_in,
   input  logic [31:0] payload_in,
   output logic        frame_n,
   output logic        valid_n,
   output logic        dout,
   output logic        busy,
   output logic        tx_done
);
`ifdef PORT_TX_PAD_EN
   typedef enum logic [2:0] {IDLE, ADDR, PAD, PAYLOAD, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, ADDR, PAYLOAD, GAP} state_t;
`endif
   state_t      state, state_nx;
   logic [4:0]  cnt, cnt_nx;
   logic        hold_vld;
   logic [3:0]  hold_addr, addr_sr, addr_nx;
   logic [31:0] hold_pay, pay_sr, pay_nx;
   logic        take, pad_nx;
   logic        frame_n_nx, valid_n_nx, dout_nx, done_nx;

   if (PAD_CYCLES < 1 || PAD_CYCLES > 15) begin : g_pad_cycles_out_of_range
   end

   assign in_ready = !hold_vld;
   assign busy = state != IDLE;

   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      addr_nx = addr_sr;
      pay_nx = pay_sr;
      take = 1'b0;
      case (state)
         IDLE, GAP: begin
            state_nx = hold_vld ? ADDR : IDLE;
            take = hold_vld;
            cnt_nx = 5'd0;
            addr_nx = hold_vld ? hold_addr : addr_sr;
            pay_nx = hold_vld ? hold_pay : pay_sr;
         end
         ADDR: begin
`ifdef PORT_TX_PAD_EN
            state_nx = (cnt == 5'd3) ? PAD : ADDR;
`else
            state_nx = (cnt == 5'd3) ? PAYLOAD : ADDR;
`endif
            cnt_nx = (cnt == 5'd3) ? 5'd0 : cnt + 5'd1;
            addr_nx = (cnt == 5'd3) ? addr_sr : addr_sr >> 1;
         end
`ifdef PORT_TX_PAD_EN
         PAD: begin
            state_nx = (cnt == 5'(PAD_CYCLES - 1)) ? PAYLOAD : PAD;
            cnt_nx = (cnt == 5'(PAD_CYCLES - 1)) ? 5'd0 : cnt + 5'd1;
         end
`endif
         PAYLOAD: begin
            state_nx = (cnt == 5'd31) ? GAP : PAYLOAD;
            cnt_nx = (cnt == 5'd31) ? 5'd0 : cnt + 5'd1;
            pay_nx = (cnt == 5'd31) ? pay_sr : pay_sr >> 1;
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef PORT_TX_PAD_EN
   assign pad_nx = state_nx == PAD;
`else
   assign pad_nx = 1'b0;
`endif

   // outputs are computed from the next state so they appear in the same cycle the state is entered
   always_comb begin
      frame_n_nx = !(state_nx == ADDR || pad_nx || (state_nx == PAYLOAD && cnt_nx != 5'd31));
      valid_n_nx = state_nx != PAYLOAD;
      dout_nx = (state_nx == ADDR) ? addr_nx[0] : (state_nx == PAYLOAD) ? pay_nx[0] : 1'b0;
      done_nx = state_nx == GAP;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt <= 5'd0;
         addr_sr <= 4'd0;
         pay_sr <= 32'd0;
         hold_vld <= 1'b0;
         hold_addr <= 4'd0;
         hold_pay <= 32'd0;
         frame_n <= 1'b1;
         valid_n <= 1'b1;
         dout <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         addr_sr <= addr_nx;
         pay_sr <= pay_nx;
         frame_n <= frame_n_nx;
         valid_n <= valid_n_nx;
         dout <= dout_nx;
         tx_done <= done_nx;
         if (take)
            hold_vld <= 1'b0;
         else if (in_valid && !hold_vld) begin
            hold_vld <= 1'b1;
            hold_addr <= addr_in;
            hold_pay <= payload_in;
         end
      end
   end
endmodule

// File: tb/tb_port_tx.sv
// tb_port_tx: self-checking bench for port_tx with a loop-back receiver model and timeline reference.
module tb_port_tx;
`ifdef PORT_TX_PAD_EN
   localparam int PADN = 3;
`else
   localparam int PADN = 0;
`endif
   localparam int PER = 37 + PADN;

   logic clock = 1'b0, reset_n = 1'b1, in_valid = 1'b0;
   logic [3:0] addr_in = 4'd0;
   logic [31:0] payload_in = 32'd0;
   logic in_ready, frame_n, valid_n, dout, busy, tx_done;

   int compared = 0, mismatched = 0, cyc = 0;
   typedef struct {logic fn, vn, d, td, bz, rdy;} smp_t;
   typedef struct {logic [3:0] a; logic [31:0] p;} pkt_t;
   smp_t tr[$];
   pkt_t sent[$], rx[$];
   int acc_cyc[$], rx_first[$];
   int na = 0, np = 0, nb = 0, rfirst = 0, rx_bad = 0, td_bad = 0, bz_bad = 0;
   logic [3:0] ra = 4'd0;
   logic [31:0] rp = 32'd0;
   logic prev_b31 = 1'b0;

   port_tx #(.PAD_CYCLES(PADN > 0 ? PADN : 2)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .addr_in(addr_in), .payload_in(payload_in), .frame_n(frame_n), .valid_n(valid_n),
      .dout(dout), .busy(busy), .tx_done(tx_done)
   );

   always #5 clock = ~clock;

   // expected {frame_n, valid_n, dout, tx_done} at offset j of a frame (j = PER-1 is the gap)
   function automatic logic [3:0] exp_smp(pkt_t k, int j);
      if (j < 4) return {1'b0, 1'b1, k.a[j], 1'b0};
      if (j < 4 + PADN) return 4'b0100;
      if (j < 36 + PADN) return {j == 35 + PADN, 1'b0, k.p[j - 4 - PADN], 1'b0};
      return 4'b1101;
   endfunction

   // one clock: record handshake, sample outputs, run the line receiver
   task automatic step();
      smp_t s;
      pkt_t t;
      logic acc;
      acc = in_valid && in_ready;
      t.a = addr_in;
      t.p = payload_in;
      @(posedge clock);
      #1;
      cyc++;
      if (acc) begin
         sent.push_back(t);
         acc_cyc.push_back(cyc);
      end
      s = '{frame_n, valid_n, dout, tx_done, busy, in_ready};
      tr.push_back(s);
      if (s.td !== prev_b31) td_bad++;
      if (s.bz !== (!s.fn || !s.vn || s.td)) bz_bad++;
      prev_b31 = !s.vn && s.fn;
      if (!s.fn || !s.vn) begin
         if (s.vn) begin
            if (na < 4) begin
               if (na == 0) rfirst = cyc;
               ra[na] = s.d;
               na++;
            end else begin
               np++;
               if (s.d) rx_bad++;
            end
         end else begin
            if (nb < 32) rp[nb] = s.d;
            nb++;
            if (s.fn) begin
               if (na == 4 && np == PADN && nb == 32) begin
                  t.a = ra;
                  t.p = rp;
                  rx.push_back(t);
                  rx_first.push_back(rfirst);
               end else rx_bad++;
               na = 0; np = 0; nb = 0;
            end
         end
      end else begin
         na = 0; np = 0; nb = 0;
      end
   endtask

   task automatic test_reset();
      #3 reset_n = 1'b0;
      #1;
      compared++;
      if ({frame_n, valid_n, dout, busy, tx_done, in_ready} !== 6'b110001) begin
         mismatched++;
         $display("FAIL reset_outputs: got fn/vn/d/busy/done/rdy=%b want 110001",
                  {frame_n, valid_n, dout, busy, tx_done, in_ready});
      end
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      step();
      compared++;
      if ({frame_n, valid_n, dout, busy, tx_done, in_ready} !== 6'b110001) begin
         mismatched++;
         $display("FAIL idle_after_reset: got %b want 110001", {frame_n, valid_n, dout, busy, tx_done, in_ready});
      end
   endtask

   task automatic test_directed();
      pkt_t k;
      int s0, r0, a0;
      k.a = 4'hA;
      k.p = 32'h8000_0001;
      s0 = sent.size();
      r0 = rx.size();
      in_valid = 1'b1; addr_in = k.a; payload_in = k.p;
      step();
      in_valid = 1'b0;
      for (int n = 0; n < PER + 1; n++) step();
      compared++;
      if (sent.size() != s0 + 1 || rx.size() != r0 + 1) begin
         mismatched++;
         $display("FAIL directed_count: accepted=%0d decoded=%0d want 1/1", sent.size() - s0, rx.size() - r0);
      end else begin
         a0 = acc_cyc[s0];
         compared++;
         if (tr[a0 - 1].rdy !== 1'b0 || tr[a0].rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL directed_ready: got %b%b want 01", tr[a0 - 1].rdy, tr[a0].rdy);
         end
         for (int j = 0; j < PER; j++) begin
            compared++;
            if ({tr[a0 + j].fn, tr[a0 + j].vn, tr[a0 + j].d, tr[a0 + j].td} !== exp_smp(k, j)) begin
               mismatched++;
               $display("FAIL directed_line[%0d]: got fn/vn/d/done=%b want %b", j,
                        {tr[a0 + j].fn, tr[a0 + j].vn, tr[a0 + j].d, tr[a0 + j].td}, exp_smp(k, j));
            end
         end
         compared++;
         if (rx[r0].a !== k.a || rx[r0].p !== k.p || rx_first[r0] != a0 + 1) begin
            mismatched++;
            $display("FAIL directed_rx: got %h/%h at %0d want %h/%h at %0d", rx[r0].a, rx[r0].p,
                     rx_first[r0], k.a, k.p, a0 + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      pkt_t p[3];
      int s0, r0, k, a0, bad;
      p[0].a = 4'h3; p[0].p = 32'h1234_5678;
      p[1].a = 4'hC; p[1].p = 32'hDEAD_BEEF;
      p[2].a = 4'($urandom()); p[2].p = $urandom();
      s0 = sent.size();
      r0 = rx.size();
      k = 0;
      in_valid = 1'b1; addr_in = p[0].a; payload_in = p[0].p;
      for (int n = 0; n < 4 * PER && rx.size() < r0 + 3; n++) begin
         step();
         if (sent.size() > s0 + k) begin
            k++;
            if (k < 3) begin
               addr_in = p[k].a; payload_in = p[k].p;
            end else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      repeat (3) step();
      compared++;
      if (sent.size() != s0 + 3 || rx.size() != r0 + 3) begin
         mismatched++;
         $display("FAIL b2b_count: accepted=%0d decoded=%0d want 3/3", sent.size() - s0, rx.size() - r0);
      end else begin
         a0 = acc_cyc[s0];
         compared++;
         if (acc_cyc[s0 + 1] - a0 != 2 || acc_cyc[s0 + 2] - a0 != PER + 2) begin
            mismatched++;
            $display("FAIL b2b_accept: offsets %0d,%0d want 2,%0d", acc_cyc[s0 + 1] - a0, acc_cyc[s0 + 2] - a0, PER + 2);
         end
         bad = 0;
         for (int c = a0 + 2; c <= a0 + PER; c++) if (tr[c - 1].rdy !== 1'b0) bad++;
         compared++;
         if (bad != 0 || tr[a0 + PER].rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_hold_full: ready-high cycles=%0d drain_ready=%b want 0/1", bad, tr[a0 + PER].rdy);
         end
         for (int i = 0; i < 3; i++) begin
            bad = 0;
            for (int j = 0; j < PER; j++)
               if ({tr[a0 + i * PER + j].fn, tr[a0 + i * PER + j].vn, tr[a0 + i * PER + j].d,
                    tr[a0 + i * PER + j].td} !== exp_smp(p[i], j)) bad++;
            compared++;
            if (bad != 0) begin
               mismatched++;
               $display("FAIL b2b_frame%0d: %0d bad cycles want 0", i, bad);
            end
            compared++;
            if (rx[r0 + i].a !== p[i].a || rx[r0 + i].p !== p[i].p || rx_first[r0 + i] != a0 + 1 + i * PER) begin
               mismatched++;
               $display("FAIL b2b_rx%0d: got %h/%h at %0d want %h/%h at %0d", i, rx[r0 + i].a, rx[r0 + i].p,
                        rx_first[r0 + i], p[i].a, p[i].p, a0 + 1 + i * PER);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      pkt_t k;
      int s0, r0, a0;
      logic [31:0] p0;
      p0 = $urandom();
      s0 = sent.size();
      in_valid = 1'b1; addr_in = 4'($urandom()); payload_in = p0;
      step();
      a0 = cyc;
      addr_in = 4'($urandom()); payload_in = $urandom();
      while (cyc < a0 + 15 + PADN) begin
         step();
         if (sent.size() >= s0 + 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      compared++;
      if (tr[cyc - 1].vn !== 1'b0 || tr[cyc - 1].d !== p0[10] || in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_bit10: got vn=%b d=%b rdy=%b want 0/%b/0", tr[cyc - 1].vn, tr[cyc - 1].d, in_ready, p0[10]);
      end
      r0 = rx.size();
      reset_n = 1'b0;
      #1;
      compared++;
      if ({frame_n, valid_n, dout, busy, tx_done, in_ready} !== 6'b110001) begin
         mismatched++;
         $display("FAIL mid_reset_outputs: got %b want 110001", {frame_n, valid_n, dout, busy, tx_done, in_ready});
      end
      #2 reset_n = 1'b1;
      repeat (3) step();
      compared++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_hold_dropped: got busy=%b rdy=%b want 0/1", busy, in_ready);
      end
      k.a = 4'($urandom()); k.p = $urandom();
      in_valid = 1'b1; addr_in = k.a; payload_in = k.p;
      step();
      in_valid = 1'b0;
      for (int n = 0; n < PER + 1; n++) step();
      compared++;
      if (rx.size() != r0 + 1) begin
         mismatched++;
         $display("FAIL mid_after_count: decoded=%0d want 1", rx.size() - r0);
      end else if (rx[r0].a !== k.a || rx[r0].p !== k.p) begin
         mismatched++;
         $display("FAIL mid_after_rx: got %h/%h want %h/%h", rx[r0].a, rx[r0].p, k.a, k.p);
      end
   endtask

   task automatic test_random();
      localparam int N = 12;
      int s0, r0, c0, k, bad, prev;
      int fst[N];
      logic full;
      s0 = sent.size();
      r0 = rx.size();
      c0 = cyc;
      k = 0;
      for (int n = 0; n < N * PER * 4 && rx.size() < r0 + N; n++) begin
         step();
         if (sent.size() > s0 + k) begin
            k++;
            in_valid = 1'b0;
         end
         if (!in_valid && k < N && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b1; addr_in = 4'($urandom()); payload_in = $urandom();
         end
      end
      in_valid = 1'b0;
      repeat (2) step();
      compared++;
      if (sent.size() != s0 + N || rx.size() != r0 + N) begin
         mismatched++;
         $display("FAIL rand_count: accepted=%0d decoded=%0d want %0d/%0d", sent.size() - s0, rx.size() - r0, N, N);
      end else begin
         prev = -1000;
         bad = 0;
         for (int i = 0; i < N; i++) begin
            fst[i] = (acc_cyc[s0 + i] + 1 > prev + PER) ? acc_cyc[s0 + i] + 1 : prev + PER;
            prev = fst[i];
            if (rx[r0 + i].a !== sent[s0 + i].a || rx[r0 + i].p !== sent[s0 + i].p || rx_first[r0 + i] != fst[i]) bad++;
         end
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("FAIL rand_frames: %0d of %0d frames wrong in content or start time", bad, N);
         end
         bad = 0;
         for (int c = c0 + 1; c <= cyc; c++) begin
            full = 1'b0;
            for (int i = 0; i < N; i++) if (acc_cyc[s0 + i] <= c && c < fst[i]) full = 1'b1;
            if (tr[c - 1].rdy !== !full) bad++;
         end
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("FAIL rand_ready: %0d cycles with wrong in_ready want 0", bad);
         end
      end
   endtask

   task automatic test_line_rules();
      compared++;
      if (rx_bad != 0 || td_bad != 0 || bz_bad != 0) begin
         mismatched++;
         $display("FAIL line_rules: framing=%0d tx_done=%0d busy=%0d errors want 0/0/0", rx_bad, td_bad, bz_bad);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_line_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
